// File: rtl/register_file_32x32.sv
// register_file_32x32: 32 x 32-bit register file, one write port, two
// registered read ports. Register 0 is hardwired to zero.
// Optional feature: define REGISTER_FILE_BYPASS_EN to forward write_data to a
// read port that addresses the register being written on the same edge
// (write-first). Without it, reads return the pre-write value.
module register_file_32x32 #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [ADDR_BITS-1:0] read_address1,
  input  logic [ADDR_BITS-1:0] read_address2,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DEPTH-1:0] write_onehot;
  logic [WIDTH-1:0] reg_q [DEPTH];
  logic [WIDTH-1:0] reg_d [DEPTH];
  logic [WIDTH-1:0] read_data1_q, read_data1_d;
  logic [WIDTH-1:0] read_data2_q, read_data2_d;

  // One-hot write enable decode; gated by write_enable first so an unknown
  // address while idle selects nothing. Bit 0 is never enabled.
  always_comb begin
    write_onehot = '0;
    if (write_enable) begin
      write_onehot[write_address] = 1'b1;
    end
    write_onehot[0] = 1'b0;
  end

  // Next state of each register: load write_data when selected, else hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      reg_d[i] = write_onehot[i] ? write_data : reg_q[i];
    end
    reg_d[0] = '0;
  end

  // Read word selection from pre-write array state, with optional forwarding.
  always_comb begin
    read_data1_d = (read_address1 == '0) ? '0 : reg_q[read_address1];
    read_data2_d = (read_address2 == '0) ? '0 : reg_q[read_address2];
`ifdef REGISTER_FILE_BYPASS_EN
    if (write_enable && (write_address != '0)) begin
      if (read_address1 == write_address) read_data1_d = write_data;
      if (read_address2 == write_address) read_data2_d = write_data;
    end
`endif
  end

  // Array and read-port registers; reset clears everything and drops writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
      end
      read_data1_q <= '0;
      read_data2_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= reg_d[i];
      end
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
    end
  end

  assign read_data1 = read_data1_q;
  assign read_data2 = read_data2_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// Testbench for register_file_32x32: directed scenarios followed by random
// traffic, checked against an array-based reference model.
module tb_register_file_32x32;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  read_address1;
  logic [4:0]  read_address2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of register contents.
  logic [31:0] model [32];

`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file_32x32 dut (
    .clk           (clk),
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address1 (read_address1),
    .read_address2 (read_address2),
    .read_data1    (read_data1),
    .read_data2    (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // One clock transaction: drive inputs, let the edge happen, predict and
  // compare both read ports, then update the model.
  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1,
                      input logic [4:0] a2, input string tag);
    logic [31:0] e1, e2;
    @(negedge clk);
    reset         = r;
    write_enable  = we;
    write_address = wa;
    write_data    = wd;
    read_address1 = a1;
    read_address2 = a2;
    @(posedge clk);
    if (r) begin
      e1 = 32'h0;
      e2 = 32'h0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else begin
      e1 = (a1 == 5'd0) ? 32'h0 : model[a1];
      e2 = (a2 == 5'd0) ? 32'h0 : model[a2];
      if (BYPASS && we && wa != 5'd0) begin
        if (a1 == wa) e1 = wd;
        if (a2 == wa) e2 = wd;
      end
      if (we && wa != 5'd0) model[wa] = wd;
    end
    #1;
    check_eq({tag, ".rd1"}, read_data1, e1);
    check_eq({tag, ".rd2"}, read_data2, e2);
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_address = '0; write_data = '0;
    read_address1 = '0; read_address2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;

    // 1: reset, then every register reads 0 on both ports
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "reset_edge");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "post_reset");
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "reset_scan");

    // 2: write r5, read r5 on port 1 and r6 on port 2
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, "wr_r5");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, "rd_r5_r6");
    check_eq("r5_value", read_data1, 32'hDEADBEEF);

    // 3: write to r0 is dropped
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr_r0");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd_r0");
    check_eq("r0_zero", read_data2, 32'h0);

    // 4: collision on port 2 with r7
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd5, 5'd7, "collide_r7");
    check_eq("collide_first", read_data2, BYPASS ? 32'h12345678 : 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, "after_collide");
    check_eq("collide_next", read_data2, 32'h12345678);

    // 5: reset wins over a simultaneous write
    step(1'b0, 1'b1, 5'd3, 32'h1, 5'd0, 5'd0, "wr_r3_1");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "rd_r3_1");
    step(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, "reset_with_wr");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, "rd_r3_after_rst");
    check_eq("r3_cleared", read_data1, 32'h0);

    // 6: walking pattern, paired readback
    for (int n = 1; n < 32; n++)
      step(1'b0, 1'b1, 5'(n), 32'(n) * 32'h01010101, 5'd0, 5'd0, "walk_wr");
    for (int n = 1; n < 32; n++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(n), 5'(32 - n), "walk_rd");

    // Idle cycles with unknown write address must not disturb the array
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 5'bx, $urandom, 5'(i + 1), 5'(i + 9), "idle_xaddr");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
           5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
